// File: rtl/mul_seq_unit_pkg.sv
// Shared types for the iterative shift-add multiply unit.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        MUL   = 2'd0,
        MLA   = 2'd1,
        UMULL = 2'd2,
        SMULL = 2'd3
    } mul_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier for MUL/MLA/UMULL/SMULL, one partial product per cycle.
// Fixed latency: done pulses WIDTH+3 cycles after the accepted start.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    mul_state_t         state_q;
    mul_op_t            op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_lo_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               flag_n_q;
    logic               flag_z_q;

    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [2*WIDTH-1:0] prod_step_d;
    logic [2*WIDTH-1:0] prod_signed_d;
    logic [WIDTH-1:0]   fix_lo_d;
    logic [WIDTH-1:0]   fix_hi_d;
    logic               fix_n_d;
    logic               fix_z_d;

    // Magnitudes for SMULL; the most negative value maps to itself, read as unsigned.
    always_comb begin
        abs_a_d = a[WIDTH-1] ? (~a + 1'b1) : a;
        abs_b_d = b[WIDTH-1] ? (~b + 1'b1) : b;
    end

    always_comb begin
        prod_step_d = prod_q;
        if (mplier_q[0]) begin
            prod_step_d = prod_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        end
    end

    always_comb begin
        prod_signed_d = neg_q ? (~prod_q + PROD_ONE) : prod_q;
        fix_lo_d      = prod_signed_d[WIDTH-1:0];
        fix_hi_d      = prod_signed_d[2*WIDTH-1:WIDTH];
        fix_n_d       = 1'b0;
        fix_z_d       = 1'b0;
        if (op_q == MLA) begin
            fix_lo_d = prod_signed_d[WIDTH-1:0] + acc_q;
            fix_hi_d = '0;
        end else if (op_q == MUL) begin
            fix_hi_d = '0;
        end
        if ((op_q == MUL) || (op_q == MLA)) begin
            fix_n_d = fix_lo_d[WIDTH-1];
            fix_z_d = (fix_lo_d == '0);
        end else begin
            fix_n_d = fix_hi_d[WIDTH-1];
            fix_z_d = (fix_lo_d == '0) && (fix_hi_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            neg_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    op_q   <= mul_op_t'(op);
                    acc_q  <= acc;
                    prod_q <= '0;
                    cnt_q  <= '0;
                    if (mul_op_t'(op) == SMULL) begin
                        mcand_q  <= abs_a_d;
                        mplier_q <= abs_b_d;
                        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        neg_q    <= 1'b0;
                    end
                    state_q <= RUN;
                end
                RUN: begin
                    prod_q   <= prod_step_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                // Results are registered on leaving FIX so they are valid during DONE.
                FIX: begin
                    result_lo_q <= fix_lo_d;
                    result_hi_q <= fix_hi_d;
                    flag_n_q    <= fix_n_d;
                    flag_z_q    <= fix_z_d;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed self-checking bench for mul_seq_unit with hand-computed products.
module tb_mul_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        flag_n;
    logic        flag_z;

    int unsigned checks;
    int unsigned errors;

    mul_seq_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op; optionally re-pulse start with other operands at edge inj_at while busy.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] iacc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_n, input logic exp_z, input int inj_at);
        int k;
        int pulses;
        op    = o;
        a     = ia;
        b     = ib;
        acc   = iacc;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        check({tag, "_busy_early"}, {63'd0, busy}, 64'd1);
        while (!done && k < 60) begin
            if (k == inj_at) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                b     = 32'hFFFF_FFFF;
                op    = 2'd2;
            end
            tick();
            start = 1'b0;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'd35);
        check({tag, "_result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
        check({tag, "_flags"}, {62'd0, flag_n, flag_z}, {62'd0, exp_n, exp_z});
        tick();
        check({tag, "_after"}, {62'd0, busy, done}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            tick();
        end
        check({tag, "_extra_done"}, 64'(pulses), 64'd0);
        check({tag, "_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        a      = '0;
        b      = '0;
        acc    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_ctrl", {62'd0, busy, done}, 64'd0);
        check("reset_res", {result_hi, result_lo}, 64'd0);
        check("reset_flags", {62'd0, flag_n, flag_z}, 64'd0);

        do_op("mul_7x6", 2'd0, 32'd7, 32'd6, 32'd0, 32'd0, 32'd42, 1'b0, 1'b0, 0);
        do_op("mla_wrap", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd0, 32'd1, 1'b0, 1'b0, 0);
        do_op("umull_max", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 0);
        do_op("smull_m3x5", 2'd3, 32'hFFFF_FFFD, 32'd5, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0, 0);
        do_op("smull_min", 2'd3, 32'h8000_0000, 32'h8000_0000, 32'd0,
              32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
        do_op("smull_zero", 2'd3, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0);
        do_op("mul_hidrop", 2'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0);
        do_op("mul_neg", 2'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'h8000_0000, 1'b1, 1'b0, 0);
        do_op("busy_start", 2'd2, 32'h1234_5678, 32'h10, 32'd0,
              32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0, 10);

        // Abort mid-RUN, then confirm no late done pulse and a clean restart.
        op    = 2'd0;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ctrl", {62'd0, busy, done}, 64'd0);
        check("abort_res", {result_hi, result_lo}, 64'd0);
        check("abort_flags", {62'd0, flag_n, flag_z}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort_quiet", 64'(seen), 64'd0);
        do_op("mul_restart", 2'd0, 32'd9, 32'd9, 32'd0, 32'd0, 32'd81, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
